product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter LEN, default 4, meaning number of products per accumulation block (legal range 2..255).
REQ-002 Parameter ACC_W, default 24, meaning accumulator and sum width in bits (legal range 17..32).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 product  input  16  signed two's-complement product from the upstream pipelined Booth multiplier.
REQ-006 prod_valid  input  1  product is valid this cycle.
REQ-007 prod_ready  output  1  block accepts product this cycle.
REQ-008 clear  input  1  synchronous abort of the current block.
REQ-009 sum  output  ACC_W  signed block sum.
REQ-010 sum_valid  output  1  sum is valid and held.
REQ-011 sum_ready  input  1  downstream accepts sum this cycle.
REQ-012 ovf  output  1  saturation occurred in the block that produced sum; valid while sum_valid=1.
REQ-013 cnt  output  8  number of products accepted in the current block.

Function
REQ-014 Two states: ACCUM and HOLD; reset state is ACCUM.
REQ-015 Product acceptance is the condition prod_valid=1 and prod_ready=1 in the same cycle.
REQ-016 prod_ready shall be 1 in ACCUM and 0 in HOLD, driven from state only, with no combinational path from prod_valid.
REQ-017 In ACCUM, each acceptance shall add the sign-extended product to acc and increment cnt.
REQ-018 Addition shall saturate to the signed ACC_W range [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any saturating add shall set a sticky block overflow flag.
REQ-019 The acceptance that makes cnt reach LEN shall load sum with the saturated total and ovf with the sticky flag, set sum_valid=1 on the next cycle, and enter HOLD.
REQ-020 Latency: sum_valid rises exactly 1 cycle after the LEN-th acceptance edge.
REQ-021 In HOLD, sum, ovf and sum_valid shall remain stable until sum_ready=1.
REQ-022 In HOLD with sum_ready=1, the block shall clear sum_valid, acc, cnt and the sticky flag, and return to ACCUM on the next cycle.
REQ-023 A product presented in the same cycle as the HOLD-to-ACCUM handoff is not accepted, because prod_ready=0 in that cycle; upstream must hold it.
REQ-024 Non-accepted cycles (prod_valid=0) shall leave acc and cnt unchanged; gaps between products are allowed.
REQ-025 clear=1 has priority over all other inputs: it zeroes acc, cnt, the sticky flag and sum_valid, and forces ACCUM on the next cycle. A product accepted in the same cycle is discarded.
REQ-026 sum and ovf shall be 0 whenever a clear or reset has occurred and no block has completed since.

Reset
REQ-027 While rst=1, asynchronously: state=ACCUM, acc=0, cnt=0, sum=0, ovf=0, sum_valid=0; prod_ready=1 after reset deasserts.
REQ-028 Reset asserted mid-block or in HOLD shall discard all partial and pending results with no sum_valid pulse.

Verification
REQ-029 LEN=4: accept products 20, -63, 20, -63 back to back -> sum_valid=1 one cycle after the 4th, sum=-86, ovf=0, cnt=4.
REQ-030 HOLD with sum_ready=0 for 5 cycles while prod_valid=1 -> prod_ready=0, sum=-86 stable; sum_ready=1 -> next cycle sum_valid=0, cnt=0, prod_ready=1.
REQ-031 ACC_W=17, LEN=4: four products of 0x7FFF -> sum=65535, ovf=1; four products of 0x8000 -> sum=-65536, ovf=1.
REQ-032 Products 5, 7 (with 2 idle cycles between), then clear=1 together with prod_valid and product 9 -> cnt=0, no sum_valid; next four products of 1 -> sum=4.
REQ-033 rst pulsed asynchronously between clock edges after 3 accepted products -> all outputs 0 immediately; the following 4 products of 2 -> sum=8.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator: sums LEN signed 16-bit products into a saturating
// ACC_W-bit accumulator, then holds the block sum until downstream takes it.
// A sticky overflow flag records whether any add in the block saturated.
module product_accumulator #(
    parameter int LEN   = 4,
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [15:0]      product,
    input  logic                    prod_valid,
    output logic                    prod_ready,
    input  logic                    clear,
    output logic signed [ACC_W-1:0] sum,
    output logic                    sum_valid,
    input  logic                    sum_ready,
    output logic                    ovf,
    output logic [7:0]              cnt
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [7:0]             LEN_CNT = 8'(LEN);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  sum_q, sum_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     sticky_q, sticky_d;
    logic                     ovf_q, ovf_d;
    logic                     sum_valid_q, sum_valid_d;

    logic                     accept;
    logic                     last;
    logic [7:0]               cnt_inc;
    logic [ACC_W:0]           add_full;
    logic signed [ACC_W-1:0]  add_sat;
    logic                     add_ovf;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clear always wins and returns to ACCUM
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM:   if (accept && last) state_d = HOLD;
                HOLD:    if (sum_ready)      state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    // Outputs decoded from state only, so prod_ready never depends on prod_valid
    always_comb begin
        prod_ready = (state_q == ACCUM);
    end

    // Saturating add: one guard bit is enough since ACC_W exceeds the product width
    always_comb begin
        accept   = prod_valid && prod_ready;
        cnt_inc  = cnt_q + 8'd1;
        last     = (cnt_inc == LEN_CNT);
        add_full = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-16){product[15]}}, product};
        add_ovf  = (add_full[ACC_W] != add_full[ACC_W-1]);
        if (add_ovf) begin
            add_sat = add_full[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            add_sat = add_full[ACC_W-1:0];
        end
    end

    // Datapath next values: clear, then HOLD handoff, then accumulation
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        sum_valid_d = sum_valid_q;
        if (clear) begin
            acc_d       = '0;
            cnt_d       = '0;
            sticky_d    = 1'b0;
            sum_d       = '0;
            ovf_d       = 1'b0;
            sum_valid_d = 1'b0;
        end else if (state_q == HOLD) begin
            // sum and ovf keep the completed block's result after the handoff
            if (sum_ready) begin
                acc_d       = '0;
                cnt_d       = '0;
                sticky_d    = 1'b0;
                sum_valid_d = 1'b0;
            end
        end else if (accept) begin
            acc_d    = add_sat;
            cnt_d    = cnt_inc;
            sticky_d = sticky_q | add_ovf;
            if (last) begin
                sum_d       = add_sat;
                ovf_d       = sticky_q | add_ovf;
                sum_valid_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign sum       = sum_q;
    assign ovf       = ovf_q;
    assign sum_valid = sum_valid_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: two instances (ACC_W=24 and ACC_W=17) share
// stimulus; a block-level model keeps the accepted products of the current
// block and folds them with saturation when the block completes.
module tb_product_accumulator;

    localparam int LEN = 4;

    logic               clk;
    logic               rst;
    logic signed [15:0] product;
    logic               prod_valid;
    logic               clear;
    logic               sum_ready;

    logic               prod_ready24, prod_ready17;
    logic signed [23:0] sum24;
    logic signed [16:0] sum17;
    logic               sum_valid24, sum_valid17;
    logic               ovf24, ovf17;
    logic [7:0]         cnt24, cnt17;

    int checks = 0;
    int errors = 0;

    // Model state
    longint             blk[$];
    bit                 hold;
    logic signed [63:0] exp_sum24, exp_sum17;
    logic               exp_ovf24, exp_ovf17;

    product_accumulator #(.LEN(LEN), .ACC_W(24)) dut24 (
        .clk(clk), .rst(rst), .product(product), .prod_valid(prod_valid),
        .prod_ready(prod_ready24), .clear(clear), .sum(sum24),
        .sum_valid(sum_valid24), .sum_ready(sum_ready), .ovf(ovf24), .cnt(cnt24)
    );

    product_accumulator #(.LEN(LEN), .ACC_W(17)) dut17 (
        .clk(clk), .rst(rst), .product(product), .prod_valid(prod_valid),
        .prod_ready(prod_ready17), .clear(clear), .sum(sum17),
        .sum_valid(sum_valid17), .sum_ready(sum_ready), .ovf(ovf17), .cnt(cnt17)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Sum of the block's products, clamping after every add as the spec demands
    function automatic void fold(input int w, output logic signed [63:0] s,
                                 output logic o);
        longint a, hi, lo;
        a  = 0;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        o  = 1'b0;
        foreach (blk[i]) begin
            a = a + blk[i];
            if (a > hi) begin
                a = hi;
                o = 1'b1;
            end else if (a < lo) begin
                a = lo;
                o = 1'b1;
            end
        end
        s = a;
    endfunction

    function automatic void model_zero();
        blk.delete();
        hold      = 1'b0;
        exp_sum24 = 0;
        exp_sum17 = 0;
        exp_ovf24 = 1'b0;
        exp_ovf17 = 1'b0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_vld24"}, 64'(sum_valid24), 64'(hold));
        chk({tag, "_vld17"}, 64'(sum_valid17), 64'(hold));
        chk({tag, "_cnt24"}, 64'(cnt24), 64'(blk.size()));
        chk({tag, "_cnt17"}, 64'(cnt17), 64'(blk.size()));
        chk({tag, "_sum24"}, sum24, exp_sum24);
        chk({tag, "_sum17"}, sum17, exp_sum17);
        chk({tag, "_ovf24"}, 64'(ovf24), 64'(exp_ovf24));
        chk({tag, "_ovf17"}, 64'(ovf17), 64'(exp_ovf17));
    endtask

    // One clock of stimulus; called and returns 1 time unit after a rising edge
    task automatic step(input logic pv, input logic signed [15:0] p,
                        input logic clr, input logic sr, input string tag);
        prod_valid = pv;
        product    = p;
        clear      = clr;
        sum_ready  = sr;
        chk({tag, "_rdy24"}, 64'(prod_ready24), 64'(!hold));
        chk({tag, "_rdy17"}, 64'(prod_ready17), 64'(!hold));
        @(posedge clk);
        #1;
        if (clr) begin
            model_zero();
        end else if (hold) begin
            if (sr) begin
                hold = 1'b0;
                blk.delete();
            end
        end else if (pv) begin
            blk.push_back(longint'(p));
            if (blk.size() == LEN) begin
                fold(24, exp_sum24, exp_ovf24);
                fold(17, exp_sum17, exp_ovf17);
                hold = 1'b1;
            end
        end
        check_all(tag);
        $display("%s pv=%0d p=%0d clr=%0d sr=%0d -> vld=%0d cnt=%0d sum24=%0d sum17=%0d ovf=%0d/%0d",
                 tag, pv, p, clr, sr, sum_valid24, cnt24, sum24, sum17, ovf24, ovf17);
    endtask

    task automatic push(input logic signed [15:0] p, input string tag);
        step(1'b1, p, 1'b0, 1'b0, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 16'sd0, 1'b0, 1'b0, tag);
    endtask

    task automatic drain(input string tag);
        step(1'b0, 16'sd0, 1'b0, 1'b1, tag);
    endtask

    // Reset pulse placed between clock edges
    task automatic async_reset(input string tag);
        prod_valid = 1'b0;
        clear      = 1'b0;
        sum_ready  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_zero();
        check_all(tag);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk({tag, "_rdy24"}, 64'(prod_ready24), 64'd1);
        chk({tag, "_rdy17"}, 64'(prod_ready17), 64'd1);
        $display("%s async reset pulse -> vld=%0d cnt=%0d sum24=%0d", tag, sum_valid24, cnt24, sum24);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic               pv, clr, sr;
        logic signed [15:0] p;

        rst        = 1'b1;
        prod_valid = 1'b0;
        product    = '0;
        clear      = 1'b0;
        sum_ready  = 1'b0;
        model_zero();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_rdy", 64'(prod_ready24), 64'd1);
        rst = 1'b0;

        // Basic block: 20, -63, 20, -63 -> -86
        push(16'sd20, "r29");
        push(-16'sd63, "r29");
        push(16'sd20, "r29");
        chk("r29_not_yet", 64'(sum_valid24), 64'd0);
        push(-16'sd63, "r29");
        chk("r29_sum", sum24, -64'sd86);
        chk("r29_cnt", 64'(cnt24), 64'd4);

        // HOLD with upstream pushing: not accepted, result stable
        for (int i = 0; i < 5; i++) step(1'b1, 16'sd100, 1'b0, 1'b0, "r30_hold");
        chk("r30_sum_stable", sum24, -64'sd86);
        // Handoff cycle: product presented but refused
        step(1'b1, 16'sd100, 1'b0, 1'b1, "r30_handoff");
        chk("r30_cnt0", 64'(cnt24), 64'd0);
        step(1'b1, 16'sd100, 1'b0, 1'b0, "r30_accept");
        step(1'b0, 16'sd0, 1'b1, 1'b0, "r30_clear");

        // Saturation on the 17-bit instance
        for (int i = 0; i < 4; i++) push(16'sh7FFF, "r31_pos");
        chk("r31_sum17_max", sum17, 64'sd65535);
        chk("r31_ovf17_max", 64'(ovf17), 64'd1);
        drain("r31_drain");
        for (int i = 0; i < 4; i++) push(16'sh8000, "r31_neg");
        chk("r31_sum17_min", sum17, -64'sd65536);
        chk("r31_ovf17_min", 64'(ovf17), 64'd1);
        drain("r31_drain");

        // Gaps, then a clear colliding with a product
        push(16'sd5, "r32");
        idle(2, "r32_gap");
        push(16'sd7, "r32");
        step(1'b1, 16'sd9, 1'b1, 1'b0, "r32_clear");
        chk("r32_cnt0", 64'(cnt24), 64'd0);
        chk("r32_sum0", sum24, 64'sd0);
        for (int i = 0; i < 4; i++) push(16'sd1, "r32_ones");
        chk("r32_sum4", sum24, 64'sd4);
        drain("r32_drain");

        // Asynchronous reset mid-block
        for (int i = 0; i < 3; i++) push(16'sd2, "r33_pre");
        async_reset("r33_rst");
        for (int i = 0; i < 4; i++) push(16'sd2, "r33_twos");
        chk("r33_sum8", sum24, 64'sd8);
        drain("r33_drain");

        // Random traffic including extremes, clears and backpressure
        for (int n = 0; n < 200; n++) begin
            pv  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 39) == 0);
            sr  = hold ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       p = 16'sh7FFF;
                1:       p = 16'sh8000;
                default: p = 16'($urandom);
            endcase
            step(pv, p, clr, sr, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
